// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - FIFO-buffered frame feeder for the FFT serial input; FFT_FEED_CNT_EN adds frame_cnt
module fft_frame_feeder #(
    parameter int N     = 4,
    parameter int DEPTH = 8,
    parameter int GAP   = 16
) (
    input  logic       fastclock,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       readyin,
    output logic [7:0] x,
    output logic       busy
`ifdef FFT_FEED_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(N);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [CW-1:0] N_CNT     = CW'(N);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] LAST_IDX  = SW'(N - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] sample_idx;
    logic [GW-1:0] gap_cnt;
    logic          push;
    logic          pop;

    // Full check uses the registered count, so a same-cycle pop never frees a slot early.
    assign in_ready = (count < DEPTH_CNT);
    assign push     = in_valid && in_ready;
    // The first pop of a frame happens on the IDLE->SEND edge, the rest while in SEND.
    assign pop      = ((state == ST_IDLE) && (count >= N_CNT)) ||
                      ((state == ST_SEND) && (sample_idx != LAST_IDX));

    // Sample storage; contents need no reset since count guards every read.
    always_ff @(posedge fastclock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge fastclock or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: waits for a whole frame, streams it, then holds the idle gap.
    always_ff @(posedge fastclock or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            readyin    <= 1'b0;
            x          <= 8'h00;
            busy       <= 1'b0;
            sample_idx <= '0;
            gap_cnt    <= '0;
`ifdef FFT_FEED_CNT_EN
            frame_cnt  <= 8'h00;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count >= N_CNT) begin
                        state      <= ST_SEND;
                        readyin    <= 1'b1;
                        busy       <= 1'b1;
                        x          <= mem[rd_ptr];
                        sample_idx <= '0;
                    end
                end
                ST_SEND: begin
                    if (sample_idx == LAST_IDX) begin
                        state     <= ST_GAP;
                        readyin   <= 1'b0;
                        x         <= 8'h00;
                        gap_cnt   <= GAP_LOAD;
`ifdef FFT_FEED_CNT_EN
                        frame_cnt <= frame_cnt + 8'd1;
`endif
                    end else begin
                        x          <= mem[rd_ptr];
                        sample_idx <= sample_idx + SW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    readyin <= 1'b0;
                    x       <= 8'h00;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - randomized and directed bench for fft_frame_feeder against a schedule model
module tb_fft_frame_feeder;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int GAP   = 16;

    logic       fastclock = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       in_ready;
    logic       readyin;
    logic [7:0] x;
    logic       busy;
`ifdef FFT_FEED_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fft_frame_feeder #(.N(N), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .fastclock (fastclock),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .readyin   (readyin),
        .x         (x),
        .busy      (busy)
`ifdef FFT_FEED_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 fastclock = ~fastclock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Schedule model: a frame may start at edge t when >= N samples are held and
    // t >= next_start; it then occupies N edges and blocks starts for GAP+1 more.
    logic [7:0] q[$];
    logic [7:0] got[$];
    int         t          = 0;
    int         sent       = N;
    int         next_start = 0;
    int         busy_until = 0;
    logic       exp_rdy    = 1'b0;
    logic [7:0] exp_x      = 8'h00;
    logic       exp_busy   = 1'b0;

    initial forever begin
        logic       push;
        logic [7:0] d;
        @(posedge fastclock or posedge rst);
        if (rst) begin
            q.delete();
            sent = N; next_start = 0; busy_until = 0;
            exp_rdy = 1'b0; exp_x = 8'h00; exp_busy = 1'b0;
        end else begin
            push = in_valid && (q.size() < DEPTH);
            d    = in_data;
            if (sent < N) begin
                exp_x = q.pop_front(); exp_rdy = 1'b1; sent++;
            end else if (q.size() >= N && t >= next_start) begin
                exp_x = q.pop_front(); exp_rdy = 1'b1; sent = 1;
                next_start = t + N + GAP + 1;
                busy_until = t + N + GAP;
            end else begin
                exp_x = 8'h00; exp_rdy = 1'b0;
            end
            exp_busy = (t < busy_until);
            if (push) q.push_back(d);
            t++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge fastclock);
        if (!rst) begin
            chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
            chk("readyin", int'(readyin), int'(exp_rdy));
            chk("x", int'(x), int'(exp_x));
            chk("busy", int'(busy), int'(exp_busy));
            if (readyin) got.push_back(x);
        end
    end

    initial begin
        logic [7:0] pat [4];
        int         saw;
        int         cyc;
        int         rise0;
        int         rise1;
        logic       prev;
        logic       acc;
        int         val;
        pat = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state.
        repeat (2) @(negedge fastclock);
        chk("rst_readyin", int'(readyin), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // One frame from an empty FIFO: latency and order.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = pat[i];
            @(negedge fastclock);
        end
        in_valid = 1'b0;
        chk("lat_not_yet", int'(readyin), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge fastclock);
            chk("frame_rdy", int'(readyin), 1);
            chk("frame_x", int'(x), int'(pat[i]));
        end
        @(negedge fastclock);
        chk("frame_end_rdy", int'(readyin), 0);
        chk("frame_end_x", int'(x), 0);

        // Partial frame waits; completing sample starts the frame next edge.
        repeat (30) @(negedge fastclock);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
            @(negedge fastclock);
        end
        in_valid = 1'b0;
        saw = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge fastclock);
            if (readyin) saw = 1;
        end
        chk("partial_hold", saw, 0);
        in_valid = 1'b1; in_data = 8'hA3;
        @(negedge fastclock);
        in_valid = 1'b0;
        chk("partial_j", int'(readyin), 0);
        @(negedge fastclock);
        chk("partial_j1_rdy", int'(readyin), 1);
        chk("partial_j1_x", int'(x), 8'hA0);

        // Saturated host: FIFO fills and frames are N+GAP+1 apart.
        repeat (30) @(negedge fastclock);
        val = 8'h80; acc = 1'b0; saw = 0; rise0 = -1; rise1 = -1; prev = 1'b0;
        for (cyc = 0; cyc < 60; cyc++) begin
            if (acc) val++;
            in_valid = 1'b1; in_data = 8'(val);
            acc = in_ready;
            if (!in_ready) saw = 1;
            if (readyin && !prev) begin
                if (rise0 < 0) rise0 = cyc;
                else if (rise1 < 0) rise1 = cyc;
            end
            prev = readyin;
            @(negedge fastclock);
        end
        chk("full_seen", saw, 1);
        chk("frame_period", rise1 - rise0, N + GAP + 1);

        // Asynchronous reset mid-frame.
        cyc = 0;
        while (!readyin && cyc < 100) begin @(negedge fastclock); cyc++; end
        chk("mid_frame_found", int'(readyin), 1);
        @(posedge fastclock);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_readyin", int'(readyin), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        in_valid = 1'b0;
        @(negedge fastclock);
        rst = 1'b0;
        got.delete();

        // Random-gap host stream 0x00..0x3F.
        val = 0; acc = 1'b0;
        while (val < 64) begin
            in_valid = 1'($urandom_range(1, 0));
            in_data  = 8'(val);
            acc = in_valid && in_ready;
            @(negedge fastclock);
            if (acc) val++;
        end
        in_valid = 1'b0;
        cyc = 0;
        while (got.size() < 64 && cyc < 2000) begin @(negedge fastclock); cyc++; end
        chk("stream_count", got.size(), 64);
        for (int i = 0; i < 64 && i < got.size(); i++) chk("stream_order", int'(got[i]), i);
`ifdef FFT_FEED_CNT_EN
        repeat (30) @(negedge fastclock);
        chk("frame_cnt_16", int'(frame_cnt), 16);

        // Counter wrap over 257 frames.
        rst = 1'b1;
        @(negedge fastclock);
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        val = 0; prev = 1'b0;
        for (cyc = 0; cyc < 257 * (N + GAP + 1) + 200 && val < 257; cyc++) begin
            @(negedge fastclock);
            if (prev && !readyin) begin
                val++;
                if (val == 255) chk("frame_cnt_255", int'(frame_cnt), 255);
                if (val == 256) chk("frame_cnt_256", int'(frame_cnt), 0);
                if (val == 257) chk("frame_cnt_257", int'(frame_cnt), 1);
            end
            prev = readyin;
        end
        chk("frames_sent", val, 257);
        in_valid = 1'b0;
`endif

        repeat (5) @(negedge fastclock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
